fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Program-counter and fetch sequencer for the 3BC processor. Owns the 10-bit instruction address driven into the instruction ROM, and sequences a program from a Start pulse to a halt. Accepts stall, absolute-jump and relative-branch requests from the decode/execute stages, and reports Done plus a cycle count to the testbench. The ROM is combinational, so the instruction for the current address is valid in the same cycle it is presented.

## Interface
Parameters:
- A_W, 10, instruction address width; PC wraps modulo 2**A_W
- OFF_W, 8, width of the signed relative-branch offset
- CNT_W, 16, width of the executed-cycle counter

Ports:
- Clk  in  1  single clock; all state changes on rising edge
- Reset  in  1  asynchronous, active-high; forces the reset state immediately
- Start  in  1  one-cycle request to begin a program; honoured only in IDLE or HALT
- StartAddr  in  A_W  first instruction address, sampled with Start
- Stall  in  1  hold PC this cycle; no counter update
- Jump  in  1  load PC with Target next cycle
- Target  in  A_W  absolute jump address
- BranchRel  in  1  PC <= PC + sign-extended Offset next cycle
- Offset  in  OFF_W  signed two's-complement relative offset
- HaltReq  in  1  the current instruction is the halt; stop after it
- InstAddress  out  A_W  PC, feeds the ROM address; reset 0
- InstValid  out  1  high only in RUN; reset 0
- Done  out  1  high in HALT, level, until the next Start; reset 0
- CycleCount  out  CNT_W  number of non-stalled RUN cycles since the last Start; reset 0

## Operation
- States: IDLE (reset state), RUN, HALT. Encoding lives in the package.
- IDLE:
  - Start=1 -> RUN; PC <= StartAddr; CycleCount <= 0.
  - All other inputs are ignored.
- RUN, with priority HaltReq > Stall > Jump > BranchRel > increment, evaluated each cycle:
  - HaltReq=1 -> HALT. PC holds. CycleCount increments once, for the halt instruction. This applies even if Stall is also high.
  - Stall=1 -> PC and CycleCount hold.
  - Jump=1 -> PC <= Target. If BranchRel is also high, it is ignored.
  - BranchRel=1 -> PC <= (PC + sext(Offset)) mod 2**A_W.
  - Otherwise PC <= (PC + 1) mod 2**A_W. Address 1023 wraps to 0.
  - Every non-stalled cycle: CycleCount <= CycleCount + 1, saturating at 2**CNT_W - 1.
- HALT:
  - PC and CycleCount hold; Done=1.
  - Start=1 -> RUN with PC <= StartAddr, CycleCount <= 0, Done cleared the next cycle.
- Start is ignored while in RUN. It does not restart the program.
- Reset, asserted at any time including mid-RUN: the block goes to IDLE, PC=0, Done=0, InstValid=0, CycleCount=0, without waiting for a clock edge.
- Relative-branch arithmetic:
  - Offset is sign-extended to A_W bits, then added.
  - The carry out is discarded, so negative offsets wrap below 0 to the top of memory (e.g. 2 + -3 = 1023).

## Timing
- Start at edge N -> InstAddress=StartAddr and InstValid=1 from edge N; the first instruction is decoded in cycle N..N+1.
- Jump, BranchRel or increment sampled at edge N -> the new InstAddress appears after edge N; the redirect costs zero bubbles.
- HaltReq sampled at edge N -> Done=1 and InstValid=0 after edge N; InstAddress still shows the halt address.
- All outputs come directly from registers, with no combinational path from inputs to outputs.
- Stall has a latency of 0 cycles: a stalled cycle repeats the same InstAddress on the next cycle.

## Structure
- Package fetch_pkg holds:
  - the state enum (IDLE, RUN, HALT);
  - the localparams A_W=10, OFF_W=8 and instruction width 9, shared with the ROM and the decoder.
- Optional combinational sub-module pc_next: takes PC, Jump, Target, BranchRel and Offset, and returns the next PC. It is reused by the decoder's branch-target checks.
- The state register, PC register and counter stay in fetch_ctrl.

## Test plan
- Reset mid-RUN at PC=0x05A -> InstAddress=0, state IDLE, Done=0 and CycleCount=0 before the next edge.
- Start with StartAddr=0x3FE, 3 free-running cycles -> addresses 0x3FE, 0x3FF, 0x000, 0x001; CycleCount=3.
- At PC=0x002, BranchRel with Offset=0xFD (-3) -> PC=0x3FF. At PC=0x010, Offset=0x7F -> PC=0x08F.
- Jump=1, BranchRel=1 and Target=0x123 in one cycle -> PC=0x123. The next cycle has Stall=1 and Jump=1 with Target=0x200 -> PC stays 0x123 and CycleCount is unchanged.
- HaltReq with Stall at PC=0x040 after 20 cycles -> Done=1, InstValid=0, InstAddress=0x040, CycleCount=21. Start during RUN has no effect. Start in HALT with StartAddr=0x100 -> RUN at 0x100, CycleCount=0.
- Run 70000 unstalled cycles -> CycleCount saturates at 0xFFFF.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and widths for the 3BC fetch path: sequencer state and the
// address/offset/instruction widths also used by the ROM and decoder.
package fetch_pkg;

    localparam int A_W    = 10;
    localparam int OFF_W  = 8;
    localparam int INST_W = 9;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

endpackage

// File: rtl/pc_next.sv
// Next-PC arithmetic for a running program: jump, relative branch or +1.
// Pure combinational so the decoder can reuse it for branch-target checks.
module pc_next #(
    parameter int A_W   = fetch_pkg::A_W,
    parameter int OFF_W = fetch_pkg::OFF_W
) (
    input  logic [A_W-1:0]   i_pc,
    input  logic             i_jump,
    input  logic [A_W-1:0]   i_target,
    input  logic             i_branch_rel,
    input  logic [OFF_W-1:0] i_offset,
    output logic [A_W-1:0]   o_next_pc
);

    logic [A_W-1:0] w_offset_sext;

    // Carry out of the add is dropped, so the PC wraps modulo 2**A_W.
    assign w_offset_sext = {{(A_W-OFF_W){i_offset[OFF_W-1]}}, i_offset};

    always_comb begin
        o_next_pc = i_pc + A_W'(1);
        if (i_jump) begin
            o_next_pc = i_target;
        end else if (i_branch_rel) begin
            o_next_pc = i_pc + w_offset_sext;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Program counter and fetch sequencer: IDLE -> RUN on Start, RUN -> HALT on
// HaltReq. Every output is a register; DbgState exposes the FSM state.
module fetch_ctrl #(
    parameter int A_W   = fetch_pkg::A_W,
    parameter int OFF_W = fetch_pkg::OFF_W,
    parameter int CNT_W = fetch_pkg::CNT_W
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic [A_W-1:0]       StartAddr,
    input  logic                 Stall,
    input  logic                 Jump,
    input  logic [A_W-1:0]       Target,
    input  logic                 BranchRel,
    input  logic [OFF_W-1:0]     Offset,
    input  logic                 HaltReq,
    output logic [A_W-1:0]       InstAddress,
    output logic                 InstValid,
    output logic                 Done,
    output logic [CNT_W-1:0]     CycleCount,
    output fetch_pkg::state_t    DbgState
);

    import fetch_pkg::*;

    state_t           r_state;
    logic [A_W-1:0]   r_pc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_inst_valid;
    logic             r_done;

    state_t           w_state_nxt;
    logic [A_W-1:0]   w_pc_nxt;
    logic [A_W-1:0]   w_pc_run;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;

    pc_next #(
        .A_W   (A_W),
        .OFF_W (OFF_W)
    ) u_pc_next (
        .i_pc         (r_pc),
        .i_jump       (Jump),
        .i_target     (Target),
        .i_branch_rel (BranchRel),
        .i_offset     (Offset),
        .o_next_pc    (w_pc_run)
    );

    // The counter sticks at all-ones rather than wrapping.
    assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE, ST_HALT: begin
                if (Start) begin
                    w_state_nxt = ST_RUN;
                    w_pc_nxt    = StartAddr;
                    w_cnt_nxt   = '0;
                end
            end
            ST_RUN: begin
                // Halt wins over Stall and still counts the halt instruction.
                if (HaltReq) begin
                    w_state_nxt = ST_HALT;
                    w_cnt_nxt   = w_cnt_inc;
                end else if (!Stall) begin
                    w_pc_nxt  = w_pc_run;
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state      <= ST_IDLE;
            r_pc         <= '0;
            r_cnt        <= '0;
            r_inst_valid <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_cnt        <= w_cnt_nxt;
            r_inst_valid <= (w_state_nxt == ST_RUN);
            r_done       <= (w_state_nxt == ST_HALT);
        end
    end

    assign InstAddress = r_pc;
    assign InstValid   = r_inst_valid;
    assign Done        = r_done;
    assign CycleCount  = r_cnt;
    assign DbgState    = r_state;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed vector table, hand-written
// corner sequences, and randomized traffic against an integer reference model.
module tb_fetch_ctrl;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic [9:0]  StartAddr;
  logic        Stall;
  logic        Jump;
  logic [9:0]  Target;
  logic        BranchRel;
  logic [7:0]  Offset;
  logic        HaltReq;
  logic [9:0]  InstAddress;
  logic        InstValid;
  logic        Done;
  logic [15:0] CycleCount;
  fetch_pkg::state_t DbgState;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_ctrl dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Start       (Start),
    .StartAddr   (StartAddr),
    .Stall       (Stall),
    .Jump        (Jump),
    .Target      (Target),
    .BranchRel   (BranchRel),
    .Offset      (Offset),
    .HaltReq     (HaltReq),
    .InstAddress (InstAddress),
    .InstValid   (InstValid),
    .Done        (Done),
    .CycleCount  (CycleCount),
    .DbgState    (DbgState)
  );

  // ---------------- clock / reset ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // mode: 0 = idle, 1 = running, 2 = halted
  int m_mode;
  int m_pc;
  int m_cnt;

  function automatic int wrap_addr(input int a);
    return ((a % 1024) + 1024) % 1024;
  endfunction

  function automatic int sat_inc(input int c);
    return (c >= 65535) ? 65535 : c + 1;
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_pc   = 0;
    m_cnt  = 0;
  endtask

  task automatic model_step();
    int soff;
    soff = (Offset >= 8'd128) ? int'(Offset) - 256 : int'(Offset);
    if (m_mode != 1) begin
      if (Start) begin
        m_mode = 1;
        m_pc   = int'(StartAddr);
        m_cnt  = 0;
      end
    end else if (HaltReq) begin
      m_mode = 2;
      m_cnt  = sat_inc(m_cnt);
    end else if (!Stall) begin
      if (Jump)           m_pc = int'(Target);
      else if (BranchRel) m_pc = wrap_addr(m_pc + soff);
      else                m_pc = wrap_addr(m_pc + 1);
      m_cnt = sat_inc(m_cnt);
    end
  endtask

  function automatic fetch_pkg::state_t mode_state(input int mode);
    if (mode == 1) return fetch_pkg::ST_RUN;
    if (mode == 2) return fetch_pkg::ST_HALT;
    return fetch_pkg::ST_IDLE;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_in();
    Start = 1'b0; StartAddr = '0; Stall = 1'b0; Jump = 1'b0;
    Target = '0; BranchRel = 1'b0; Offset = '0; HaltReq = 1'b0;
  endtask

  task automatic cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    idle_in();
    Reset = 1'b1;
    cycle();
    Reset = 1'b0;
    model_reset();
  endtask

  // ---------------- scoreboard ----------------
  logic [29:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic [9:0] e_addr, input logic e_valid,
                            input logic e_done, input logic [15:0] e_cnt);
    fetch_pkg::state_t e_st;
    e_st = e_valid ? fetch_pkg::ST_RUN : (e_done ? fetch_pkg::ST_HALT : fetch_pkg::ST_IDLE);
    check({tag, ".addr"},  32'(InstAddress), 32'(e_addr));
    check({tag, ".valid"}, 32'(InstValid),   32'(e_valid));
    check({tag, ".done"},  32'(Done),        32'(e_done));
    check({tag, ".cnt"},   32'(CycleCount),  32'(e_cnt));
    check({tag, ".state"}, 32'(DbgState),    32'(e_st));
  endtask

  task automatic push_model();
    exp_q.push_back({2'(mode_state(m_mode)), m_mode == 1, m_mode == 2, 10'(m_pc), 16'(m_cnt)});
  endtask

  task automatic pop_check(input string tag);
    logic [29:0] e;
    e = exp_q.pop_front();
    check({tag, ".addr"},  32'(InstAddress), 32'(e[25:16]));
    check({tag, ".valid"}, 32'(InstValid),   32'(e[27]));
    check({tag, ".done"},  32'(Done),        32'(e[26]));
    check({tag, ".cnt"},   32'(CycleCount),  32'(e[15:0]));
    check({tag, ".state"}, 32'(DbgState),    32'(e[29:28]));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        start;
    logic [9:0]  start_addr;
    logic        stall;
    logic        jump;
    logic [9:0]  target;
    logic        br;
    logic [7:0]  offset;
    logic        halt;
    logic [9:0]  exp_addr;
    logic        exp_valid;
    logic        exp_done;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[16];

  initial begin
    // Columns: start, start_addr, stall, jump, target, br, offset, halt | addr, valid, done, cnt
    vecs[0]  = '{1'b1, 10'h3FE, 1'b0, 1'b0, 10'h000, 1'b0, 8'h00, 1'b0, 10'h3FE, 1'b1, 1'b0, 16'd0};
    vecs[1]  = '{1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 1'b0, 8'h00, 1'b0, 10'h3FF, 1'b1, 1'b0, 16'd1};
    vecs[2]  = '{1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 1'b0, 8'h00, 1'b0, 10'h000, 1'b1, 1'b0, 16'd2};
    vecs[3]  = '{1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 1'b0, 8'h00, 1'b0, 10'h001, 1'b1, 1'b0, 16'd3};
    vecs[4]  = '{1'b0, 10'h000, 1'b0, 1'b1, 10'h002, 1'b0, 8'h00, 1'b0, 10'h002, 1'b1, 1'b0, 16'd4};
    vecs[5]  = '{1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 1'b1, 8'hFD, 1'b0, 10'h3FF, 1'b1, 1'b0, 16'd5};
    vecs[6]  = '{1'b0, 10'h000, 1'b0, 1'b1, 10'h010, 1'b0, 8'h00, 1'b0, 10'h010, 1'b1, 1'b0, 16'd6};
    vecs[7]  = '{1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 1'b1, 8'h7F, 1'b0, 10'h08F, 1'b1, 1'b0, 16'd7};
    vecs[8]  = '{1'b0, 10'h000, 1'b0, 1'b1, 10'h123, 1'b1, 8'h05, 1'b0, 10'h123, 1'b1, 1'b0, 16'd8};
    vecs[9]  = '{1'b0, 10'h000, 1'b1, 1'b1, 10'h200, 1'b0, 8'h00, 1'b0, 10'h123, 1'b1, 1'b0, 16'd8};
    vecs[10] = '{1'b1, 10'h300, 1'b0, 1'b0, 10'h000, 1'b0, 8'h00, 1'b0, 10'h124, 1'b1, 1'b0, 16'd9};
    vecs[11] = '{1'b0, 10'h000, 1'b1, 1'b0, 10'h000, 1'b0, 8'h00, 1'b1, 10'h124, 1'b0, 1'b1, 16'd10};
    vecs[12] = '{1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 1'b0, 8'h00, 1'b0, 10'h124, 1'b0, 1'b1, 16'd10};
    vecs[13] = '{1'b0, 10'h000, 1'b0, 1'b1, 10'h000, 1'b1, 8'h10, 1'b0, 10'h124, 1'b0, 1'b1, 16'd10};
    vecs[14] = '{1'b1, 10'h100, 1'b0, 1'b0, 10'h000, 1'b0, 8'h00, 1'b0, 10'h100, 1'b1, 1'b0, 16'd0};
    vecs[15] = '{1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 1'b1, 8'h80, 1'b0, 10'h080, 1'b1, 1'b0, 16'd1};
  end

  // ---------------- test sequence ----------------
  initial begin
    idle_in();
    Reset = 1'b0;
    #1;
    Reset = 1'b1;
    #2;
    check_outs("reset", 10'h000, 1'b0, 1'b0, 16'd0);
    cycle();
    Reset = 1'b0;
    model_reset();

    // Directed table
    for (int i = 0; i < 16; i++) begin
      Start = vecs[i].start;   StartAddr = vecs[i].start_addr;
      Stall = vecs[i].stall;   Jump = vecs[i].jump;   Target = vecs[i].target;
      BranchRel = vecs[i].br;  Offset = vecs[i].offset; HaltReq = vecs[i].halt;
      cycle();
      check_outs($sformatf("vec%0d", i), vecs[i].exp_addr, vecs[i].exp_valid,
                 vecs[i].exp_done, vecs[i].exp_cnt);
    end

    // Asynchronous reset mid-RUN at PC=0x05A, checked before any edge
    do_reset();
    Start = 1'b1; StartAddr = 10'h058;
    cycle();
    idle_in();
    cycle();
    cycle();
    check_outs("pre_rst", 10'h05A, 1'b1, 1'b0, 16'd2);
    #2;
    Reset = 1'b1;
    #1;
    check_outs("async_rst", 10'h000, 1'b0, 1'b0, 16'd0);
    @(negedge Clk);
    Reset = 1'b0;
    cycle();

    // Halt with Stall at 0x040 after 20 counted cycles, then restart from HALT
    Start = 1'b1; StartAddr = 10'h02C;
    cycle();
    idle_in();
    for (int i = 0; i < 20; i++) cycle();
    check_outs("pre_halt", 10'h040, 1'b1, 1'b0, 16'd20);
    HaltReq = 1'b1; Stall = 1'b1;
    cycle();
    check_outs("halt_stall", 10'h040, 1'b0, 1'b1, 16'd21);
    idle_in();
    Start = 1'b1; StartAddr = 10'h100;
    cycle();
    check_outs("restart", 10'h100, 1'b1, 1'b0, 16'd0);

    // Counter saturation over 70000 unstalled cycles
    idle_in();
    for (int k = 1; k <= 70000; k++) begin
      cycle();
      if (k == 65534) check("sat_m1", 32'(CycleCount), 32'hFFFE);
      if (k == 65535) check("sat_hit", 32'(CycleCount), 32'hFFFF);
      if (k == 65536) check("sat_hold", 32'(CycleCount), 32'hFFFF);
    end
    check_outs("sat_end", 10'(wrap_addr(256 + 70000)), 1'b1, 1'b0, 16'hFFFF);
    HaltReq = 1'b1;
    cycle();
    check_outs("sat_halt", 10'(wrap_addr(256 + 70000)), 1'b0, 1'b1, 16'hFFFF);

    // Randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        Reset = 1'b1;
        #1;
        model_reset();
        push_model();
        pop_check("rnd_rst");
        Reset = 1'b0;
      end
      Start     = (m_mode == 1) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 2) == 0);
      StartAddr = 10'($urandom_range(0, 1023));
      Stall     = ($urandom_range(0, 4) == 0);
      Jump      = ($urandom_range(0, 5) == 0);
      Target    = 10'($urandom_range(0, 1023));
      BranchRel = ($urandom_range(0, 3) == 0);
      Offset    = 8'($urandom_range(0, 255));
      HaltReq   = ($urandom_range(0, 39) == 0);
      model_step();
      push_model();
      cycle();
      pop_check($sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
